fetch_ctrl: RTL and testbench

//  Fetch-stage sequencer for the RISC-V core: owns the program counter, issues one instruction-memory

---
 rtl/fetch_ctrl_if.sv | 29 ++
 rtl/fetch_ctrl.sv | 157 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, EX redirect and IF/ID handoff.
`default_nettype none

interface fetch_ctrl_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_exc;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, fetch_exc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, fetch_exc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );
endinterface

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and single-outstanding instruction fetch sequencer with one-entry IF/ID buffer.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
`default_nettype none

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  fetch_ctrl_if.master  bus
);

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t      r_state, w_state_n;
  logic [31:0] r_pc, w_pc_n;
  logic        r_if_valid, w_if_valid_n;
  logic [31:0] r_if_instr, w_if_instr_n;
  logic [31:0] r_if_pc, w_if_pc_n;
  logic [31:0] w_redirect_target;
  logic        w_misaligned;
  logic        w_exc;
  logic        w_inflight;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_exc, w_exc_n;

  assign w_redirect_target = bus.redirect_pc;
  assign w_misaligned      = |bus.redirect_pc[1:0];
  assign w_exc             = r_exc;

  // Flag tracks the alignment of the most recent redirect; only a redirect changes it.
  always_comb begin
    w_exc_n = r_exc;
    if (bus.redirect_valid) begin
      w_exc_n = w_misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exc <= 1'b0;
    end else begin
      r_exc <= w_exc_n;
    end
  end
`else
  assign w_redirect_target = bus.redirect_pc & ~32'h0000_0003;
  assign w_misaligned      = 1'b0;
  assign w_exc             = 1'b0;
`endif

  always_comb begin
    w_state_n    = r_state;
    w_pc_n       = r_pc;
    w_if_valid_n = r_if_valid;
    w_if_instr_n = r_if_instr;
    w_if_pc_n    = r_if_pc;
    // Set when a request will still be outstanding after this edge.
    w_inflight   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (!w_exc) begin
          w_state_n = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.imem_req_ready) begin
          w_state_n  = S_WAIT;
          w_inflight = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          w_if_instr_n = bus.imem_rsp_data;
          w_if_pc_n    = r_pc;
          w_if_valid_n = 1'b1;
          w_pc_n       = r_pc + 32'(PC_STEP);
          w_state_n    = S_HOLD;
        end else begin
          w_inflight = 1'b1;
        end
      end
      S_HOLD: begin
        if (r_if_valid && bus.if_ready) begin
          w_if_valid_n = 1'b0;
          w_state_n    = S_REQ;
        end
      end
      S_DROP: begin
        if (bus.imem_rsp_valid) begin
          w_state_n = w_exc ? S_IDLE : S_REQ;
        end else begin
          w_inflight = 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    // A redirect wins over any sequential update, including a coincident response.
    if (bus.redirect_valid) begin
      w_pc_n       = w_redirect_target;
      w_if_valid_n = 1'b0;
      w_if_instr_n = r_if_instr;
      w_if_pc_n    = r_if_pc;
      if (w_inflight) begin
        w_state_n = S_DROP;
      end else if (w_misaligned) begin
        w_state_n = S_IDLE;
      end else begin
        w_state_n = S_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_instr <= C_NOP;
      r_if_pc    <= 32'h0000_0000;
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      r_if_valid <= w_if_valid_n;
      r_if_instr <= w_if_instr_n;
      r_if_pc    <= w_if_pc_n;
    end
  end

  assign bus.imem_req_valid = (r_state == S_REQ);
  assign bus.imem_req_addr  = r_pc;
  assign bus.if_valid       = r_if_valid;
  assign bus.if_instr       = r_if_instr;
  assign bus.if_pc          = r_if_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.fetch_exc      = r_exc;
`else
  assign bus.fetch_exc      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// Directed cycle-vector bench for fetch_ctrl: table of per-cycle inputs/expected outputs plus corner sequences.
`default_nettype none

module tb_fetch_ctrl;

  logic clk;
  logic rst;
  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {rst, req_ready, rsp_valid, redirect_valid}; fl = {req_valid, if_valid, fetch_exc}
  typedef struct {
    logic [3:0]  ctl;
    logic        ifr;
    logic [31:0] data;
    logic [31:0] rpc;
    logic [2:0]  fl;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] ipc;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   failures;

  task automatic add(input logic [3:0] ctl, input logic ifr, input logic [31:0] data,
                     input logic [31:0] rpc, input logic [2:0] fl, input logic [31:0] addr,
                     input logic [31:0] instr, input logic [31:0] ipc);
    vec_t v;
    v.ctl = ctl; v.ifr = ifr; v.data = data; v.rpc = rpc;
    v.fl = fl; v.addr = addr; v.instr = instr; v.ipc = ipc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] ctl, input logic ifr, input logic [31:0] data,
                      input logic [31:0] rpc);
    rst                = ctl[3];
    bus.imem_req_ready = ctl[2];
    bus.imem_rsp_valid = ctl[1];
    bus.redirect_valid = ctl[0];
    bus.imem_rsp_data  = data;
    bus.redirect_pc    = rpc;
    bus.if_ready       = ifr;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [2:0] fl, input logic [31:0] addr,
                            input logic [31:0] instr, input logic [31:0] ipc);
    chk({tag, " req_valid"}, {31'b0, bus.imem_req_valid}, {31'b0, fl[2]});
    chk({tag, " req_addr"},  bus.imem_req_addr, addr);
    chk({tag, " if_valid"},  {31'b0, bus.if_valid}, {31'b0, fl[1]});
    chk({tag, " if_instr"},  bus.if_instr, instr);
    chk({tag, " if_pc"},     bus.if_pc, ipc);
    chk({tag, " fetch_exc"}, {31'b0, bus.fetch_exc}, {31'b0, fl[0]});
  endtask

  logic [31:0] resume_addr;

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.if_ready       = 1'b0;

    // Reset, three sequential fetches at 0/4/8
    add(4'b1000, 1'b0, 32'h0,         32'h0,  3'b000, 32'h00, 32'h0000_0013, 32'h0);
    add(4'b1000, 1'b0, 32'h0,         32'h0,  3'b000, 32'h00, 32'h0000_0013, 32'h0);
    add(4'b0100, 1'b0, 32'h0,         32'h0,  3'b100, 32'h00, 32'h0000_0013, 32'h0);
    add(4'b0100, 1'b0, 32'h0,         32'h0,  3'b000, 32'h00, 32'h0000_0013, 32'h0);
    add(4'b0010, 1'b0, 32'hA000_0000, 32'h0,  3'b010, 32'h04, 32'hA000_0000, 32'h0);
    add(4'b0000, 1'b1, 32'h0,         32'h0,  3'b100, 32'h04, 32'hA000_0000, 32'h0);
    add(4'b0100, 1'b0, 32'h0,         32'h0,  3'b000, 32'h04, 32'hA000_0000, 32'h0);
    add(4'b0010, 1'b0, 32'hA000_0004, 32'h0,  3'b010, 32'h08, 32'hA000_0004, 32'h4);
    add(4'b0000, 1'b1, 32'h0,         32'h0,  3'b100, 32'h08, 32'hA000_0004, 32'h4);
    add(4'b0100, 1'b0, 32'h0,         32'h0,  3'b000, 32'h08, 32'hA000_0004, 32'h4);
    add(4'b0010, 1'b0, 32'hA000_0008, 32'h0,  3'b010, 32'h0C, 32'hA000_0008, 32'h8);
    // Decode stalls for five cycles: buffer stable, no request
    for (int i = 0; i < 5; i++)
      add(4'b0100, 1'b0, 32'h0,       32'h0,  3'b010, 32'h0C, 32'hA000_0008, 32'h8);
    add(4'b0000, 1'b1, 32'h0,         32'h0,  3'b100, 32'h0C, 32'hA000_0008, 32'h8);
    // Redirect to 100 while waiting; stale response dropped
    add(4'b0100, 1'b0, 32'h0,         32'h0,  3'b000, 32'h0C, 32'hA000_0008, 32'h8);
    add(4'b0001, 1'b0, 32'h0,         32'h64, 3'b000, 32'h64, 32'hA000_0008, 32'h8);
    add(4'b0010, 1'b0, 32'hDEAD_BEEF, 32'h0,  3'b100, 32'h64, 32'hA000_0008, 32'h8);
    add(4'b0100, 1'b0, 32'h0,         32'h0,  3'b000, 32'h64, 32'hA000_0008, 32'h8);
    add(4'b0010, 1'b0, 32'hA000_0064, 32'h0,  3'b010, 32'h68, 32'hA000_0064, 32'h64);
    add(4'b0000, 1'b1, 32'h0,         32'h0,  3'b100, 32'h68, 32'hA000_0064, 32'h64);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ctl, vecs[i].ifr, vecs[i].data, vecs[i].rpc);
      expect_all($sformatf("vec[%0d]", i), vecs[i].fl, vecs[i].addr, vecs[i].instr, vecs[i].ipc);
    end

    // Memory backpressure: address held, exactly one fetch after acceptance
    for (int i = 0; i < 4; i++) begin
      step(4'b0000, 1'b0, 32'h0, 32'h0);
      expect_all("stall_req", 3'b100, 32'h68, 32'hA000_0064, 32'h64);
    end
    step(4'b0100, 1'b0, 32'h0, 32'h0);
    expect_all("accept", 3'b000, 32'h68, 32'hA000_0064, 32'h64);
    for (int i = 0; i < 2; i++) begin
      step(4'b0100, 1'b0, 32'h0, 32'h0);
      expect_all("single_fetch", 3'b000, 32'h68, 32'hA000_0064, 32'h64);
    end
    step(4'b0010, 1'b0, 32'hA000_0068, 32'h0);
    expect_all("stall_rsp", 3'b010, 32'h6C, 32'hA000_0068, 32'h68);
    step(4'b0000, 1'b1, 32'h0, 32'h0);
    expect_all("stall_consume", 3'b100, 32'h6C, 32'hA000_0068, 32'h68);

    // Reset while waiting, response arrives during reset
    step(4'b0100, 1'b0, 32'h0, 32'h0);
    expect_all("pre_rst_wait", 3'b000, 32'h6C, 32'hA000_0068, 32'h68);
    step(4'b1010, 1'b0, 32'hBADB_AD00, 32'h0);
    expect_all("rst_in_wait", 3'b000, 32'h0, 32'h0000_0013, 32'h0);
    step(4'b0000, 1'b0, 32'h0, 32'h0);
    expect_all("rst_resume", 3'b100, 32'h0, 32'h0000_0013, 32'h0);

`ifdef FETCH_MISALIGN_TRAP_EN
    step(4'b0001, 1'b0, 32'h0, 32'h102);
    expect_all("misalign_trap", 3'b001, 32'h102, 32'h0000_0013, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step(4'b0100, 1'b0, 32'h0, 32'h0);
      expect_all("misalign_park", 3'b001, 32'h102, 32'h0000_0013, 32'h0);
    end
    step(4'b0001, 1'b0, 32'h0, 32'h200);
    expect_all("misalign_clear", 3'b100, 32'h200, 32'h0000_0013, 32'h0);
    resume_addr = 32'h200;
`else
    step(4'b0001, 1'b0, 32'h0, 32'h102);
    expect_all("misalign_forced", 3'b100, 32'h100, 32'h0000_0013, 32'h0);
    resume_addr = 32'h100;
`endif

    // Redirect coincident with response: response discarded, new target wins
    step(4'b0100, 1'b0, 32'h0, 32'h0);
    expect_all("coinc_wait", 3'b000, resume_addr, 32'h0000_0013, 32'h0);
    step(4'b0011, 1'b0, 32'hCAFE_F00D, 32'h300);
    expect_all("coinc_redirect", 3'b100, 32'h300, 32'h0000_0013, 32'h0);

    // PC wrap at top of address space, then redirect flushes the buffer
    step(4'b0001, 1'b0, 32'h0, 32'hFFFF_FFFC);
    expect_all("wrap_req", 3'b100, 32'hFFFF_FFFC, 32'h0000_0013, 32'h0);
    step(4'b0100, 1'b0, 32'h0, 32'h0);
    expect_all("wrap_wait", 3'b000, 32'hFFFF_FFFC, 32'h0000_0013, 32'h0);
    step(4'b0010, 1'b0, 32'h1111_1111, 32'h0);
    expect_all("wrap_rsp", 3'b010, 32'h0, 32'h1111_1111, 32'hFFFF_FFFC);
    step(4'b0001, 1'b0, 32'h0, 32'h40);
    expect_all("hold_flush", 3'b100, 32'h40, 32'h1111_1111, 32'hFFFF_FFFC);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect with a fetch outstanding: drop stale response, then park
    step(4'b0100, 1'b0, 32'h0, 32'h0);
    expect_all("trap_inflight_wait", 3'b000, 32'h40, 32'h1111_1111, 32'hFFFF_FFFC);
    step(4'b0001, 1'b0, 32'h0, 32'h43);
    expect_all("trap_drop", 3'b001, 32'h43, 32'h1111_1111, 32'hFFFF_FFFC);
    step(4'b0010, 1'b0, 32'h5555_5555, 32'h0);
    expect_all("trap_drop_rsp", 3'b001, 32'h43, 32'h1111_1111, 32'hFFFF_FFFC);
    step(4'b0000, 1'b0, 32'h0, 32'h0);
    expect_all("trap_parked", 3'b001, 32'h43, 32'h1111_1111, 32'hFFFF_FFFC);
    step(4'b0001, 1'b0, 32'h0, 32'h80);
    expect_all("trap_resume", 3'b100, 32'h80, 32'h1111_1111, 32'hFFFF_FFFC);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
